// File: rtl/aes_shift_rows_stage_if.sv
// Beat-level bundle for the ShiftRows pipeline stage: upstream beat, downstream beat,
// synchronous flush and occupancy. The stage takes the slave view; its environment takes the master view.
interface aes_shift_rows_stage_if;
  logic         clear_i;
  logic         mode_i;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] data_o;
  logic [1:0]   occ_o;

  modport master (
    output clear_i, mode_i, valid_i, data_i, ready_i,
    input  ready_o, valid_o, data_o, occ_o
  );

  modport slave (
    input  clear_i, mode_i, valid_i, data_i, ready_i,
    output ready_o, valid_o, data_o, occ_o
  );
endinterface

// File: rtl/aes_shift_rows_stage.sv
// AES ShiftRows / InvShiftRows stage with a 2-entry valid/ready skid buffer.
// Only permuted data is stored. ready_o depends on registered state only.
module aes_shift_rows_stage #(
  parameter bit OutputZero = 1'b1
) (
  input logic              clk_i,
  input logic              rst_ni,
  aes_shift_rows_stage_if.slave bus
);

  // Byte k of the state is row k%4, column k/4. A row is gathered into a 32-bit word and rotated
  // by r bytes: forward takes column c+r, inverse takes column c-r.
  function automatic logic [127:0] shift_rows(input logic [127:0] d, input logic inv);
    logic [31:0]  row;
    logic [63:0]  dbl;
    logic [31:0]  rot;
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        row[8*c +: 8] = d[8*(4*c+r) +: 8];
      end
      dbl = {row, row};
      rot = inv ? dbl[32-8*r +: 32] : dbl[8*r +: 32];
      for (int c = 0; c < 4; c++) begin
        o[8*(4*c+r) +: 8] = rot[8*c +: 8];
      end
    end
    return o;
  endfunction

  logic [127:0] head_q;
  logic [127:0] skid_q;
  logic         vh_q;
  logic         vs_q;

  logic [127:0] perm;
  logic         accept;
  logic         pop;

  always_comb begin
    perm   = shift_rows(bus.data_i, bus.mode_i);
    accept = bus.valid_i & ~vs_q;
    pop    = vh_q & bus.ready_i;
  end

  // Clear wins over any accept or pop in the same cycle; the incoming beat is discarded.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q <= '0;
      skid_q <= '0;
      vh_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else if (bus.clear_i) begin
      vh_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      unique case ({vh_q, vs_q})
        2'b00: begin
          if (accept) begin
            head_q <= perm;
            vh_q   <= 1'b1;
          end
        end
        2'b10: begin
          if (accept && pop) begin
            head_q <= perm;
          end else if (accept) begin
            skid_q <= perm;
            vs_q   <= 1'b1;
          end else if (pop) begin
            vh_q <= 1'b0;
          end
        end
        2'b11: begin
          if (pop) begin
            head_q <= skid_q;
            vs_q   <= 1'b0;
          end
        end
        default: begin
          vh_q <= 1'b0;
          vs_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.valid_o = vh_q;
    bus.ready_o = ~vs_q;
    bus.occ_o   = {1'b0, vh_q} + {1'b0, vs_q};
    bus.data_o  = (OutputZero && !vh_q) ? '0 : head_q;
  end

  a_skid_implies_head: assert property (@(posedge clk_i) disable iff (!rst_ni) vs_q |-> vh_q);

  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (vh_q && !bus.ready_i && !bus.clear_i) |=> (vh_q && $stable(head_q)));

endmodule

// File: tb/tb_aes_shift_rows_stage.sv
// Randomised scoreboard bench for aes_shift_rows_stage: a negedge monitor mirrors every accepted
// beat into a queue through a matrix-level ShiftRows model and checks pops, occupancy and ready.
module tb_aes_shift_rows_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_shift_rows_stage_if bus();

  aes_shift_rows_stage #(.OutputZero(1'b1)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [127:0] sb[$];

  localparam logic [127:0] Pattern = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] FwdExp  = 128'h0b06010c_07020d08_030e0904_0f0a0500;
  localparam logic [127:0] InvExp  = 128'h0306090c_0f020508_0b0e0104_070a0d00;

  function automatic logic [127:0] ref_shift(input logic [127:0] d, input logic inv);
    logic [7:0]   st [4][4];
    logic [127:0] o;
    int           src;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) st[r][c] = d[8*(4*c+r) +: 8];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = inv ? (c - r + 4) % 4 : (c + r) % 4;
        o[8*(4*c+r) +: 8] = st[r][src];
      end
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: queue length is the expected occupancy; head of queue is the expected data_o.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      check("occ_o", 128'(bus.occ_o), 128'(sb.size()));
      check("valid_o", 128'(bus.valid_o), 128'(sb.size() != 0));
      check("ready_o", 128'(bus.ready_o), 128'(sb.size() < 2));
      check("occ_max", 128'(bus.occ_o <= 2'd2), 128'(1));
      if (sb.size() != 0) check("data_o", bus.data_o, sb[0]);
      else check("data_idle_zero", bus.data_o, 128'd0);
      if (bus.clear_i) begin
        sb.delete();
      end else begin
        if (bus.valid_o && bus.ready_i && sb.size() != 0) begin
          void'(sb.pop_front());
          n_pop++;
        end
        if (bus.valid_i && bus.ready_o) sb.push_back(ref_shift(bus.data_i, bus.mode_i));
      end
    end
  end

  task automatic check_empty_now(input string name);
    check({name, "_valid"}, 128'(bus.valid_o), 128'(0));
    check({name, "_occ"}, 128'(bus.occ_o), 128'(0));
    check({name, "_ready"}, 128'(bus.ready_o), 128'(1));
    check({name, "_data"}, bus.data_o, 128'd0);
  endtask

  task automatic fill_two();
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1; bus.data_i = rand128(); bus.mode_i = 1'($urandom);
    step();
    bus.data_i = rand128(); bus.mode_i = 1'($urandom);
    step();
    bus.valid_i = 1'b0; bus.data_i = 'x;
    check("fill_occ2", 128'(bus.occ_o), 128'(2));
  endtask

  task automatic drain(input string name);
    int budget;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    budget = 0;
    while (bus.occ_o != 2'd0 && budget < 20) begin
      step();
      budget++;
    end
    check({name, "_drained"}, 128'(bus.occ_o), 128'(0));
  endtask

  logic [127:0] a_beat, b_beat, c_beat, r_beat;
  int           sent, cycles, pop_base;
  logic         acc;

  initial begin
    bus.clear_i = 1'b0; bus.mode_i = 1'b0; bus.valid_i = 1'b0;
    bus.data_i  = 'x;   bus.ready_i = 1'b0;
    #1;
    check_empty_now("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Directed forward then inverse on the counting pattern.
    for (int m = 0; m < 2; m++) begin
      step();
      bus.valid_i = 1'b1; bus.data_i = Pattern; bus.mode_i = 1'(m); bus.ready_i = 1'b1;
      step();
      bus.valid_i = 1'b0; bus.data_i = 'x;
      check("dir_valid", 128'(bus.valid_o), 128'(1));
      check(m == 0 ? "dir_fwd" : "dir_inv", bus.data_o, m == 0 ? FwdExp : InvExp);
      step();
      check("dir_after_valid", 128'(bus.valid_o), 128'(0));
      check("dir_after_data", bus.data_o, 128'd0);
    end

    // Alternating mode at full rate.
    bus.ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.valid_i = 1'b1; bus.data_i = rand128(); bus.mode_i = 1'(i);
      step();
    end
    drain("alt");

    // Backpressure: A, B fill the buffer, C is held until space frees up.
    bus.ready_i = 1'b0;
    a_beat = rand128(); b_beat = rand128(); c_beat = rand128();
    bus.valid_i = 1'b1; bus.data_i = a_beat; bus.mode_i = 1'b0;
    step();
    check("bp_occ1", 128'(bus.occ_o), 128'(1));
    bus.data_i = b_beat; bus.mode_i = 1'b1;
    step();
    check("bp_occ2", 128'(bus.occ_o), 128'(2));
    check("bp_ready_low", 128'(bus.ready_o), 128'(0));
    bus.data_i = c_beat; bus.mode_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_occ", 128'(bus.occ_o), 128'(2));
    end
    bus.ready_i = 1'b1;
    step();
    check("bp_ready_back", 128'(bus.ready_o), 128'(1));
    check("bp_head_b", bus.data_o, ref_shift(b_beat, 1'b1));
    step();
    bus.valid_i = 1'b0; bus.data_i = 'x;
    check("bp_head_c", bus.data_o, ref_shift(c_beat, 1'b0));
    step();
    check("bp_empty", 128'(bus.occ_o), 128'(0));

    // Random streaming at ~50% valid/ready.
    pop_base = n_pop;
    sent = 0;
    cycles = 0;
    while (sent < 100 && cycles < 5000) begin
      bus.ready_i = 1'($urandom);
      if (!bus.valid_i && ($urandom % 2 == 0)) begin
        bus.valid_i = 1'b1; bus.data_i = rand128(); bus.mode_i = 1'($urandom);
      end
      acc = bus.valid_i && bus.ready_o;
      step();
      if (acc) begin
        sent++;
        bus.valid_i = 1'b0; bus.data_i = 'x;
      end
      cycles++;
    end
    check("stream_sent", 128'(sent), 128'(100));
    drain("stream");
    check("stream_popped", 128'(n_pop - pop_base), 128'(100));

    // Clear with a full buffer and a beat offered in the clear cycle.
    fill_two();
    bus.valid_i = 1'b1; bus.data_i = rand128(); bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0; bus.valid_i = 1'b0; bus.data_i = 'x;
    check_empty_now("clear");
    bus.ready_i = 1'b1;
    repeat (3) step();

    // Asynchronous reset between edges with a full buffer.
    fill_two();
    #3 rst_n = 1'b0;
    #1;
    check_empty_now("async_rst");
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    r_beat = rand128();
    bus.valid_i = 1'b1; bus.data_i = r_beat; bus.mode_i = 1'b1; bus.ready_i = 1'b1;
    step();
    bus.valid_i = 1'b0; bus.data_i = 'x;
    check("rst_first_valid", 128'(bus.valid_o), 128'(1));
    check("rst_first_data", bus.data_o, ref_shift(r_beat, 1'b1));
    step();
    check("rst_first_gone", 128'(bus.valid_o), 128'(0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
